// File: rtl/dot_product_engine.sv
// Streaming fixed-point dot-product engine: LANES pixel/weight pairs per beat,
// product/reduce/accumulate pipeline onto a bias with signed saturation.
module dot_product_engine #(
    parameter int  PIXEL_SIZE  = 10,
    parameter int  WEIGHT_SIZE = 19,
    parameter int  ACC_SIZE    = 26,
    parameter int  LANES       = 4,
    parameter int  MAX_LEN     = 784,
    parameter int  PROD_SHIFT  = 3,
    localparam int LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         GlobalReset,
    input  logic                         start,
    input  logic [LEN_W-1:0]             vec_len,
    input  logic signed [ACC_SIZE-1:0]   bias,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*PIXEL_SIZE-1:0]  pixel_in,
    input  logic [LANES*WEIGHT_SIZE-1:0] weight_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_SIZE-1:0]   result,
    output logic                         sat_flag,
    output logic                         busy
);
    localparam int LOG_LANES = $clog2(LANES);
    localparam int PROD_W    = WEIGHT_SIZE + PIXEL_SIZE + 1;
    localparam int SUM_W     = PROD_W + LOG_LANES;
    localparam int EXT_W     = ((SUM_W > ACC_SIZE) ? SUM_W : ACC_SIZE) + 1;
    localparam logic signed [EXT_W-1:0] ACC_MAX_EXT =
        {{(EXT_W-ACC_SIZE+1){1'b0}}, {(ACC_SIZE-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN_EXT =
        {{(EXT_W-ACC_SIZE+1){1'b1}}, {(ACC_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                     state_reg, state_next;
    logic [LEN_W-1:0]           beats_left_reg;
    logic [LEN_W-1:0]           tail_reg;
    logic                       in_vld_reg, in_last_reg;
    logic                       s1_vld_reg, s1_last_reg;
    logic                       s2_vld_reg, s2_last_reg;
    logic signed [SUM_W-1:0]    sum_reg;
    logic signed [ACC_SIZE-1:0] acc_reg;
    logic                       sat_reg;

    logic [LEN_W-1:0]           len_clamped, beats_start, tail_start;
    logic [LEN_W:0]             round_up;
    logic                       accept, last_beat;
    logic signed [PROD_W-1:0]   prod_lane [LANES];
    logic signed [SUM_W-1:0]    lane_sum;
    logic signed [EXT_W-1:0]    acc_ext, sum_ext, total;
    logic signed [ACC_SIZE-1:0] acc_sat;
    logic                       sat_hit;

    // Beat count and number of live lanes in the final beat, fixed at start.
    always_comb begin
        len_clamped = (vec_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : vec_len;
        round_up    = {1'b0, len_clamped} + (LEN_W+1)'(LANES - 1);
        beats_start = LEN_W'(round_up >> LOG_LANES);
        tail_start  = len_clamped - ((beats_start - LEN_W'(1)) << LOG_LANES);
    end

    assign accept    = (state_reg == RUN) && in_valid;
    assign last_beat = (beats_left_reg == LEN_W'(1));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PIXEL_SIZE-1:0]          pix_reg;
            logic signed [WEIGHT_SIZE-1:0]  wgt_reg;
            logic signed [PROD_W-1:0]       prod_reg;
            logic signed [PROD_W-1:0]       prod_full;
            logic                           lane_en;

            // Lanes beyond the vector end are zeroed at capture so they add nothing.
            assign lane_en   = !last_beat || (LEN_W'(gi) < tail_reg);
            assign prod_full = PROD_W'(wgt_reg) * PROD_W'($signed({1'b0, pix_reg}));

            always_ff @(posedge clk) begin
                if (GlobalReset) begin
                    pix_reg  <= '0;
                    wgt_reg  <= '0;
                    prod_reg <= '0;
                end else begin
                    if (accept) begin
                        pix_reg <= lane_en ? pixel_in[gi*PIXEL_SIZE +: PIXEL_SIZE] : '0;
                        wgt_reg <= lane_en ? weight_in[gi*WEIGHT_SIZE +: WEIGHT_SIZE] : '0;
                    end
                    if (in_vld_reg) begin
                        prod_reg <= prod_full >>> PROD_SHIFT;
                    end
                end
            end

            assign prod_lane[gi] = prod_reg;
        end
    endgenerate

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SUM_W'(prod_lane[i]);
        end
    end

    always_comb begin
        acc_ext = EXT_W'(acc_reg);
        sum_ext = EXT_W'(sum_reg);
        total   = acc_ext + sum_ext;
        sat_hit = 1'b0;
        acc_sat = ACC_SIZE'(total);
        if (total > ACC_MAX_EXT) begin
            acc_sat = ACC_SIZE'(ACC_MAX_EXT);
            sat_hit = 1'b1;
        end else if (total < ACC_MIN_EXT) begin
            acc_sat = ACC_SIZE'(ACC_MIN_EXT);
            sat_hit = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (len_clamped == '0) ? DONE : RUN;
            RUN:     if (accept && last_beat) state_next = DRAIN;
            DRAIN:   if (s2_vld_reg && s2_last_reg) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_reg      <= IDLE;
            beats_left_reg <= '0;
            tail_reg       <= '0;
            in_vld_reg     <= 1'b0;
            in_last_reg    <= 1'b0;
            s1_vld_reg     <= 1'b0;
            s1_last_reg    <= 1'b0;
            s2_vld_reg     <= 1'b0;
            s2_last_reg    <= 1'b0;
            sum_reg        <= '0;
            acc_reg        <= '0;
            sat_reg        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            in_vld_reg  <= accept;
            in_last_reg <= accept && last_beat;
            s1_vld_reg  <= in_vld_reg;
            s1_last_reg <= in_last_reg;
            s2_vld_reg  <= s1_vld_reg;
            s2_last_reg <= s1_last_reg;
            if (s1_vld_reg) begin
                sum_reg <= lane_sum;
            end
            if (state_reg == IDLE && start) begin
                beats_left_reg <= beats_start;
                tail_reg       <= tail_start;
                acc_reg        <= bias;
                sat_reg        <= 1'b0;
            end else begin
                if (accept) begin
                    beats_left_reg <= beats_left_reg - LEN_W'(1);
                end
                if (s2_vld_reg) begin
                    acc_reg <= acc_sat;
                    if (sat_hit) sat_reg <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = (state_reg == RUN);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign result    = acc_reg;
    assign sat_flag  = sat_reg;

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine: element-level reference model plus a
// per-cycle compare process on the result handshake.
module tb_dot_product_engine;
    localparam int PIXEL_SIZE  = 10;
    localparam int WEIGHT_SIZE = 19;
    localparam int ACC_SIZE    = 26;
    localparam int LANES       = 4;
    localparam int MAX_LEN     = 784;
    localparam int PROD_SHIFT  = 3;
    localparam int LEN_W       = $clog2(MAX_LEN + 1);
    localparam int ARR_N       = MAX_LEN + LANES;

    logic                         clk = 1'b0;
    logic                         GlobalReset = 1'b1;
    logic                         start = 1'b0;
    logic [LEN_W-1:0]             vec_len = '0;
    logic signed [ACC_SIZE-1:0]   bias = '0;
    logic                         in_valid = 1'b0;
    logic                         in_ready;
    logic [LANES*PIXEL_SIZE-1:0]  pixel_in = '0;
    logic [LANES*WEIGHT_SIZE-1:0] weight_in = '0;
    logic                         out_valid;
    logic                         out_ready = 1'b0;
    logic signed [ACC_SIZE-1:0]   result;
    logic                         sat_flag;
    logic                         busy;

    int     pix_arr [ARR_N];
    int     wgt_arr [ARR_N];
    int     n_checks = 0;
    int     n_fail = 0;
    int     txn = 0;
    bit     armed = 1'b0;
    longint exp_result = 0;
    bit     exp_sat = 1'b0;

    dot_product_engine dut (
        .clk(clk), .GlobalReset(GlobalReset), .start(start), .vec_len(vec_len),
        .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
        .weight_in(weight_in), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference: element-wise products floored by 2^PROD_SHIFT, summed per beat,
    // clamped to the signed accumulator range after every beat.
    function automatic void model(input int len, input longint b, output longint r, output bit s);
        int     eff, beats, idx;
        longint acc, lsum, p, hi, lo;
        hi  = (longint'(1) << (ACC_SIZE - 1)) - 1;
        lo  = -(longint'(1) << (ACC_SIZE - 1));
        eff = (len > MAX_LEN) ? MAX_LEN : len;
        beats = (eff + LANES - 1) / LANES;
        acc = b;
        s   = 1'b0;
        for (int bt = 0; bt < beats; bt++) begin
            lsum = 0;
            for (int l = 0; l < LANES; l++) begin
                idx = bt * LANES + l;
                if (idx < eff) begin
                    p = longint'(wgt_arr[idx]) * longint'(pix_arr[idx]);
                    lsum += p >>> PROD_SHIFT;
                end
            end
            acc += lsum;
            if (acc > hi) begin
                acc = hi;
                s = 1'b1;
            end else if (acc < lo) begin
                acc = lo;
                s = 1'b1;
            end
        end
        r = acc;
    endfunction

    always @(negedge clk) begin
        if (!GlobalReset && out_valid) begin
            if (!armed) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("cmp_result", longint'(result), exp_result);
                check("cmp_sat_flag", longint'(sat_flag), longint'(exp_sat));
                check("cmp_busy_in_done", longint'(busy), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int pix, input int wgt);
        for (int i = 0; i < ARR_N; i++) begin
            pix_arr[i] = pix;
            wgt_arr[i] = wgt;
        end
    endtask

    task automatic send_beat(input int bt);
        int guard;
        bit rdy;
        guard = 0;
        for (int l = 0; l < LANES; l++) begin
            pixel_in[l*PIXEL_SIZE +: PIXEL_SIZE]    = PIXEL_SIZE'(pix_arr[bt*LANES+l]);
            weight_in[l*WEIGHT_SIZE +: WEIGHT_SIZE] = WEIGHT_SIZE'(wgt_arr[bt*LANES+l]);
        end
        in_valid = 1'b1;
        do begin
            rdy = in_ready;
            tick();
            guard++;
        end while (!rdy && guard < 200);
        if (!rdy) check("beat_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input int len, input longint b,
                          input longint lit_r, input bit lit_s,
                          input int gap_pct, input int hold);
        longint mr;
        bit     ms;
        int     eff, beats, lat;
        model(len, b, mr, ms);
        check({tag, "_model_result"}, mr, lit_r);
        check({tag, "_model_sat"}, longint'(ms), longint'(lit_s));
        exp_result = mr;
        exp_sat    = ms;
        armed      = 1'b1;
        eff   = (len > MAX_LEN) ? MAX_LEN : len;
        beats = (eff + LANES - 1) / LANES;
        out_ready = (hold == 0);
        start   = 1'b1;
        vec_len = LEN_W'(len);
        bias    = ACC_SIZE'(b);
        tick();
        start = 1'b0;
        for (int bt = 0; bt < beats; bt++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                pixel_in  = '1;
                weight_in = '1;
                repeat ($urandom_range(3, 1)) tick();
            end
            send_beat(bt);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, (eff == 0) ? 0 : 3);
        check({tag, "_result"}, longint'(result), lit_r);
        check({tag, "_sat_flag"}, longint'(sat_flag), longint'(lit_s));
        for (int h = 0; h < hold; h++) begin
            start   = (h == hold / 2);
            vec_len = LEN_W'(4);
            tick();
            start = 1'b0;
            check({tag, "_hold_out_valid"}, longint'(out_valid), 1);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        vec_len   = LEN_W'(4);
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check({tag, "_release_out_valid"}, longint'(out_valid), 0);
        check({tag, "_release_busy"}, longint'(busy), 0);
        check({tag, "_result_kept"}, longint'(result), lit_r);
        armed = 1'b0;
        txn++;
        $display("txn %0d %s len=%0d bias=%0d result=%0d sat=%0d latency=%0d",
                 txn, tag, len, b, longint'(result), sat_flag, lat);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, longint'(in_ready), 0);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_sat_flag"}, longint'(sat_flag), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_result"}, longint'(result), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        GlobalReset = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        GlobalReset = 1'b0;
        tick();

        fill(8, 1);
        run_op("basic4", 4, 0, 4, 1'b0, 0, 0);

        fill(8, 1);
        pix_arr[6] = 1023; wgt_arr[6] = 1000;
        pix_arr[7] = 1023; wgt_arr[7] = 1000;
        run_op("masked6", 6, 0, 6, 1'b0, 0, 0);

        fill(1, -1);
        pix_arr[3] = 1023; wgt_arr[3] = 262143;
        run_op("floor3", 3, 100, 97, 1'b0, 0, 2);

        fill(1023, -8);
        run_op("full784", 784, 0, -802032, 1'b0, 30, 0);

        fill(1023, 262143);
        run_op("sat_pos", 4, 0, 33554431, 1'b1, 0, 0);

        fill(1023, -262144);
        run_op("sat_neg", 4, -33554432, -33554432, 1'b1, 0, 0);

        fill(8, 1);
        run_op("hold10", 4, 7, 11, 1'b0, 0, 10);

        fill(1, 8);
        run_op("clamp1000", 1000, 0, 784, 1'b0, 0, 0);

        fill(1023, -8);
        start   = 1'b1;
        vec_len = LEN_W'(784);
        bias    = '0;
        tick();
        start = 1'b0;
        for (int bt = 0; bt < 50; bt++) send_beat(bt);
        in_valid    = 1'b1;
        GlobalReset = 1'b1;
        tick();
        GlobalReset = 1'b0;
        in_valid    = 1'b0;
        check_all_zero("midrun_reset");
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_reset_idle_busy", longint'(busy), 0);
        end
        txn++;
        $display("txn %0d midrun_reset beats=50 busy=%0d out_valid=%0d", txn, busy, out_valid);

        run_op("zero_len", 0, -5, -5, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
